// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t : sequencer states (HALT is only reachable when the
//                   misaligned-redirect trap is built in)
//   PC_W          : program-counter width in bits
//   INST_BYTES    : bytes per instruction, i.e. the sequential PC step
package fetch_pkg;

   localparam int PC_W       = 32;
   localparam int INST_BYTES = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for a memory with one cycle of
// registered read latency. Owns the fetch PC and drives the memory's
// flush/stall controls. It also reports which PC is currently on the memory
// output and whether that output is a real instruction or a bubble.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : misaligned redirects are refused, pulse misalign_trap and
//               park the sequencer in HALT until an aligned redirect arrives
//   undefined : redirect_pc[1:0] is forced to 00; no HALT, no trap ports
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   begin fetching (only looked at in IDLE)
//   is_stall       in   decode cannot accept an instruction this cycle
//   redirect_valid in   redirect request from execute
//   redirect_pc    in   redirect target byte address
//   imem_pc        out  fetch address to the instruction memory
//   imem_flush     out  memory flush (output register <- 0)
//   imem_stoll     out  memory stall (output register holds)
//   if_pc          out  address of the instruction on the memory output
//   if_valid       out  memory output is a real instruction
//   misalign_trap  out  one-cycle trap pulse (macro only)
//   misalign_addr  out  last refused target (macro only)
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset; memory flushed, waiting for start
// RUN   | fetching; redirect > stall > sequential increment
// HALT  | misaligned redirect refused; flushed until an aligned redirect
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            is_stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-1:0] imem_pc,
   output logic            imem_flush,
   output logic            imem_stoll,
   output logic [PC_W-1:0] if_pc,
   output logic            if_valid
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            misalign_trap,
   output logic [PC_W-1:0] misalign_addr
`endif
);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0] if_pc_q, if_pc_d;
   logic            if_valid_q, if_valid_d;
   logic [PC_W-1:0] redirect_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic            misalign_trap_q, misalign_trap_d;
   logic [PC_W-1:0] misalign_addr_q, misalign_addr_d;
   logic            redirect_misaligned;

   assign redirect_tgt        = redirect_pc;
   assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
`else
   // Low bits are cleared rather than dropped so the whole port stays in use.
   assign redirect_tgt = redirect_pc & ~(PC_W'(INST_BYTES - 1));
`endif

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      if_pc_d    = if_pc_q;
      if_valid_d = if_valid_q;
      imem_flush = 1'b0;
      imem_stoll = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_trap_d = 1'b0;
      misalign_addr_d = misalign_addr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            imem_flush = 1'b1;
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (redirect_valid) begin
               // Redirect wins over stall: the in-flight fetch is stale anyway.
               imem_flush = 1'b1;
               if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
               if (redirect_misaligned) begin
                  misalign_trap_d = 1'b1;
                  misalign_addr_d = redirect_pc;
                  state_d         = ST_HALT;
               end else begin
                  fetch_pc_d = redirect_tgt;
               end
`else
               fetch_pc_d = redirect_tgt;
`endif
            end else if (is_stall) begin
               imem_stoll = 1'b1;
            end else begin
               if_pc_d    = fetch_pc_q;
               if_valid_d = 1'b1;
               fetch_pc_d = fetch_pc_q + PC_W'(INST_BYTES);
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         ST_HALT: begin
            imem_flush = 1'b1;
            if_valid_d = 1'b0;
            if (redirect_valid) begin
               if (redirect_misaligned) begin
                  misalign_trap_d = 1'b1;
                  misalign_addr_d = redirect_pc;
               end else begin
                  fetch_pc_d = redirect_tgt;
                  state_d    = ST_RUN;
               end
            end
         end
`endif
         default: begin
            imem_flush = 1'b1;
            if_valid_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_VECTOR;
         if_pc_q    <= RESET_VECTOR;
         if_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_trap_q <= 1'b0;
         misalign_addr_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         if_pc_q    <= if_pc_d;
         if_valid_q <= if_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_trap_q <= misalign_trap_d;
         misalign_addr_q <= misalign_addr_d;
`endif
      end
   end

   assign imem_pc  = fetch_pc_q;
   assign if_pc    = if_pc_q;
   assign if_valid = if_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign_trap = misalign_trap_q;
   assign misalign_addr = misalign_addr_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl with a behavioural
// single-cycle instruction memory. Directed tasks push expected values into
// a scoreboard queue as stimulus is driven and pop/compare them one edge
// later; the random task uses a small reference model of the sequencer.
// Build with FETCH_MISALIGN_TRAP_EN defined to exercise the trap path.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_pc;
   logic        imem_flush;
   logic        imem_stoll;
   logic [31:0] if_pc;
   logic        if_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign_trap;
   logic [31:0] misalign_addr;
`endif
   logic [31:0] inst;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .is_stall       (is_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_pc        (imem_pc),
      .imem_flush     (imem_flush),
      .imem_stoll     (imem_stoll),
      .if_pc          (if_pc),
      .if_valid       (if_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .misalign_trap  (misalign_trap),
      .misalign_addr  (misalign_addr)
`endif
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
   endfunction

   // Instruction memory: registered output, not reset.
   always_ff @(posedge clk) begin
      if (imem_flush)       inst <= '0;
      else if (!imem_stoll) inst <= memf(imem_pc);
   end

   typedef struct packed {
      logic        s;
      logic        st;
      logic        rv;
      logic [31:0] rpc;
      logic        fl;
      logic        sl;
      logic        v;
      logic [31:0] pc;
   } stim_t;

   typedef struct packed {
      logic        fl;
      logic        sl;
      logic        v;
      logic [31:0] pc;
      logic        ofl;
      logic        osl;
   } exp_t;

   exp_t sb[$];

   function automatic stim_t mk(input logic s, st, rv, input logic [31:0] rpc,
                                input logic fl, sl, v, input logic [31:0] pc);
      stim_t t;
      t.s = s; t.st = st; t.rv = rv; t.rpc = rpc;
      t.fl = fl; t.sl = sl; t.v = v; t.pc = pc;
      return t;
   endfunction

   // Applies one cycle of inputs, records the expectation, advances one edge.
   task automatic drive(input stim_t t);
      exp_t e;
      start = t.s; is_stall = t.st; redirect_valid = t.rv; redirect_pc = t.rpc;
      e.fl = t.fl; e.sl = t.sl; e.v = t.v; e.pc = t.pc;
      #1;
      e.ofl = imem_flush;
      e.osl = imem_stoll;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      stim_t t;
      exp_t  e;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset if_valid: got %b want 0", if_valid); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset if_pc: got %h want 0", if_pc); end
      checks++; if (imem_pc !== 32'h0) begin errors++; $display("FAIL reset imem_pc: got %h want 0", imem_pc); end
      checks++; if (imem_flush !== 1'b1) begin errors++; $display("FAIL reset imem_flush: got %b want 1", imem_flush); end
      checks++; if (imem_stoll !== 1'b0) begin errors++; $display("FAIL reset imem_stoll: got %b want 0", imem_stoll); end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         // stall/redirect must be ignored while idle
         t = mk(1'b0, i[0], ~i[0], 32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
         drive(t);
         e = sb.pop_front();
         checks++; if (e.ofl !== e.fl) begin errors++; $display("FAIL idle flush %0d: got %b want %b", i, e.ofl, e.fl); end
         checks++; if (e.osl !== e.sl) begin errors++; $display("FAIL idle stoll %0d: got %b want %b", i, e.osl, e.sl); end
         checks++; if (if_valid !== e.v) begin errors++; $display("FAIL idle if_valid %0d: got %b want %b", i, if_valid, e.v); end
      end
      checks++; if (imem_pc !== 32'h0) begin errors++; $display("FAIL idle imem_pc: got %h want 0", imem_pc); end
   endtask

   task automatic test_start();
      stim_t t[4];
      exp_t  e;
      t[0] = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      t[1] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
      t[2] = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4);
      t[3] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8);
      for (int i = 0; i < 4; i++) begin
         drive(t[i]);
         e = sb.pop_front();
         checks++; if (e.ofl !== e.fl) begin errors++; $display("FAIL start flush %0d: got %b want %b", i, e.ofl, e.fl); end
         checks++; if (e.osl !== e.sl) begin errors++; $display("FAIL start stoll %0d: got %b want %b", i, e.osl, e.sl); end
         checks++; if (if_valid !== e.v) begin errors++; $display("FAIL start if_valid %0d: got %b want %b", i, if_valid, e.v); end
         if (e.v) begin
            checks++; if (if_pc !== e.pc) begin errors++; $display("FAIL start if_pc %0d: got %h want %h", i, if_pc, e.pc); end
            checks++; if (inst !== memf(e.pc)) begin errors++; $display("FAIL start inst %0d: got %h want %h", i, inst, memf(e.pc)); end
         end
      end
   endtask

   task automatic test_stall();
      stim_t t[4];
      exp_t  e;
      for (int i = 0; i < 3; i++) t[i] = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8);
      t[3] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hC);
      for (int i = 0; i < 4; i++) begin
         drive(t[i]);
         e = sb.pop_front();
         checks++; if (e.ofl !== e.fl) begin errors++; $display("FAIL stall flush %0d: got %b want %b", i, e.ofl, e.fl); end
         checks++; if (e.osl !== e.sl) begin errors++; $display("FAIL stall stoll %0d: got %b want %b", i, e.osl, e.sl); end
         checks++; if (if_valid !== e.v) begin errors++; $display("FAIL stall if_valid %0d: got %b want %b", i, if_valid, e.v); end
         checks++; if (if_pc !== e.pc) begin errors++; $display("FAIL stall if_pc %0d: got %h want %h", i, if_pc, e.pc); end
         checks++; if (inst !== memf(e.pc)) begin errors++; $display("FAIL stall inst %0d: got %h want %h", i, inst, memf(e.pc)); end
      end
   endtask

   task automatic test_redirect_over_stall();
      stim_t t[3];
      exp_t  e;
      t[0] = mk(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
      t[1] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h100);
      t[2] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h104);
      for (int i = 0; i < 3; i++) begin
         drive(t[i]);
         e = sb.pop_front();
         checks++; if (e.ofl !== e.fl) begin errors++; $display("FAIL redir flush %0d: got %b want %b", i, e.ofl, e.fl); end
         checks++; if (e.osl !== e.sl) begin errors++; $display("FAIL redir stoll %0d: got %b want %b", i, e.osl, e.sl); end
         checks++; if (if_valid !== e.v) begin errors++; $display("FAIL redir if_valid %0d: got %b want %b", i, if_valid, e.v); end
         if (e.v) begin
            checks++; if (if_pc !== e.pc) begin errors++; $display("FAIL redir if_pc %0d: got %h want %h", i, if_pc, e.pc); end
            checks++; if (inst !== memf(e.pc)) begin errors++; $display("FAIL redir inst %0d: got %h want %h", i, inst, memf(e.pc)); end
         end else begin
            checks++; if (inst !== 32'h0) begin errors++; $display("FAIL redir bubble inst %0d: got %h want 0", i, inst); end
         end
      end
   endtask

   task automatic test_wrap();
      stim_t t[4];
      exp_t  e;
      t[0] = mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0);
      t[1] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      t[2] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
      t[3] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0004);
      for (int i = 0; i < 4; i++) begin
         drive(t[i]);
         e = sb.pop_front();
         checks++; if (e.ofl !== e.fl) begin errors++; $display("FAIL wrap flush %0d: got %b want %b", i, e.ofl, e.fl); end
         checks++; if (if_valid !== e.v) begin errors++; $display("FAIL wrap if_valid %0d: got %b want %b", i, if_valid, e.v); end
         if (e.v) begin
            checks++; if (if_pc !== e.pc) begin errors++; $display("FAIL wrap if_pc %0d: got %h want %h", i, if_pc, e.pc); end
         end
      end
   endtask

   task automatic test_async_reset();
      stim_t t[7];
      exp_t  e;
      t[0] = mk(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
      t[1] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h40);
      t[2] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0);
      t[3] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0);
      t[4] = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0);
      t[5] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0);
      t[6] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h4);
      for (int i = 0; i < 7; i++) begin
         if (i == 2) begin
            #3 rst_n = 1'b0;
            #1;
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL arst if_valid: got %b want 0", if_valid); end
            checks++; if (imem_flush !== 1'b1) begin errors++; $display("FAIL arst imem_flush: got %b want 1", imem_flush); end
            checks++; if (imem_pc !== 32'h0) begin errors++; $display("FAIL arst imem_pc: got %h want 0", imem_pc); end
            checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL arst if_pc: got %h want 0", if_pc); end
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
         drive(t[i]);
         e = sb.pop_front();
         checks++; if (e.ofl !== e.fl) begin errors++; $display("FAIL arst flush %0d: got %b want %b", i, e.ofl, e.fl); end
         checks++; if (if_valid !== e.v) begin errors++; $display("FAIL arst if_valid %0d: got %b want %b", i, if_valid, e.v); end
         if (e.v) begin
            checks++; if (if_pc !== e.pc) begin errors++; $display("FAIL arst if_pc %0d: got %h want %h", i, if_pc, e.pc); end
         end
      end
   endtask

`ifdef FETCH_MISALIGN_TRAP_EN
   task automatic test_misalign();
      stim_t       t[5];
      exp_t        e;
      logic        wtrap[5];
      logic [31:0] waddr[5];
      t[0] = mk(1'b0, 1'b0, 1'b1, 32'h102, 1'b1, 1'b0, 1'b0, 32'h0);
      t[1] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0);
      t[2] = mk(1'b0, 1'b0, 1'b1, 32'h306, 1'b1, 1'b0, 1'b0, 32'h0);
      t[3] = mk(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0);
      t[4] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h200);
      wtrap = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      waddr = '{32'h102, 32'h102, 32'h306, 32'h306, 32'h306};
      for (int i = 0; i < 5; i++) begin
         drive(t[i]);
         e = sb.pop_front();
         checks++; if (e.ofl !== e.fl) begin errors++; $display("FAIL mis flush %0d: got %b want %b", i, e.ofl, e.fl); end
         checks++; if (e.osl !== e.sl) begin errors++; $display("FAIL mis stoll %0d: got %b want %b", i, e.osl, e.sl); end
         checks++; if (if_valid !== e.v) begin errors++; $display("FAIL mis if_valid %0d: got %b want %b", i, if_valid, e.v); end
         checks++; if (misalign_trap !== wtrap[i]) begin errors++; $display("FAIL mis trap %0d: got %b want %b", i, misalign_trap, wtrap[i]); end
         checks++; if (misalign_addr !== waddr[i]) begin errors++; $display("FAIL mis addr %0d: got %h want %h", i, misalign_addr, waddr[i]); end
         if (i == 0) begin
            checks++; if (imem_pc !== 32'h8) begin errors++; $display("FAIL mis imem_pc held: got %h want 8", imem_pc); end
         end
         if (e.v) begin
            checks++; if (if_pc !== e.pc) begin errors++; $display("FAIL mis if_pc %0d: got %h want %h", i, if_pc, e.pc); end
         end
      end
   endtask
`else
   task automatic test_align_forced();
      stim_t t[2];
      exp_t  e;
      t[0] = mk(1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 1'b0, 1'b0, 32'h0);
      t[1] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h100);
      for (int i = 0; i < 2; i++) begin
         drive(t[i]);
         e = sb.pop_front();
         checks++; if (e.ofl !== e.fl) begin errors++; $display("FAIL align flush %0d: got %b want %b", i, e.ofl, e.fl); end
         checks++; if (if_valid !== e.v) begin errors++; $display("FAIL align if_valid %0d: got %b want %b", i, if_valid, e.v); end
         if (e.v) begin
            checks++; if (if_pc !== e.pc) begin errors++; $display("FAIL align if_pc %0d: got %h want %h", i, if_pc, e.pc); end
            checks++; if (inst !== memf(e.pc)) begin errors++; $display("FAIL align inst %0d: got %h want %h", i, inst, memf(e.pc)); end
         end
      end
   endtask
`endif

   // Random traffic against a reference model (0 idle, 1 run, 2 halt).
   task automatic test_back_to_back();
      stim_t       t;
      exp_t        e;
      int          m_st;
      logic [31:0] m_fpc, m_ipc, m_maddr, tgt;
      logic        m_val, m_trap, mis;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_st = 0; m_fpc = 32'h0; m_ipc = 32'h0; m_val = 1'b0; m_trap = 1'b0; m_maddr = 32'h0;
      for (int i = 0; i < 300; i++) begin
         t.s   = ($urandom_range(0, 3) == 0);
         t.st  = ($urandom_range(0, 3) == 0);
         t.rv  = ($urandom_range(0, 5) == 0);
         t.rpc = {$urandom_range(0, 32'hFFFF), 14'h0, 2'(($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3))};
`ifdef FETCH_MISALIGN_TRAP_EN
         tgt = t.rpc;
         mis = (t.rpc[1:0] != 2'b00);
`else
         tgt = {t.rpc[31:2], 2'b00};
         mis = 1'b0;
`endif
         t.fl = (m_st != 1) || t.rv;
         t.sl = (m_st == 1) && !t.rv && t.st;
         m_trap = 1'b0;
         if (m_st == 0) begin
            if (t.s) m_st = 1;
         end else if (m_st == 1) begin
            if (t.rv) begin
               m_val = 1'b0;
               if (mis) begin m_trap = 1'b1; m_maddr = t.rpc; m_st = 2; end
               else m_fpc = tgt;
            end else if (!t.st) begin
               m_ipc = m_fpc; m_val = 1'b1; m_fpc = m_fpc + 32'd4;
            end
         end else if (t.rv) begin
            if (mis) begin m_trap = 1'b1; m_maddr = t.rpc; end
            else begin m_fpc = tgt; m_st = 1; end
         end
         t.v  = m_val;
         t.pc = m_ipc;
         drive(t);
         e = sb.pop_front();
         checks++; if (e.ofl !== e.fl) begin errors++; $display("FAIL b2b flush %0d: got %b want %b", i, e.ofl, e.fl); end
         checks++; if (e.osl !== e.sl) begin errors++; $display("FAIL b2b stoll %0d: got %b want %b", i, e.osl, e.sl); end
         checks++; if (if_valid !== e.v) begin errors++; $display("FAIL b2b if_valid %0d: got %b want %b", i, if_valid, e.v); end
         checks++; if (imem_pc !== m_fpc) begin errors++; $display("FAIL b2b imem_pc %0d: got %h want %h", i, imem_pc, m_fpc); end
         if (e.v) begin
            checks++; if (if_pc !== e.pc) begin errors++; $display("FAIL b2b if_pc %0d: got %h want %h", i, if_pc, e.pc); end
            checks++; if (inst !== memf(e.pc)) begin errors++; $display("FAIL b2b inst %0d: got %h want %h", i, inst, memf(e.pc)); end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         checks++; if (misalign_trap !== m_trap) begin errors++; $display("FAIL b2b trap %0d: got %b want %b", i, misalign_trap, m_trap); end
         checks++; if (misalign_addr !== m_maddr) begin errors++; $display("FAIL b2b addr %0d: got %h want %h", i, misalign_addr, m_maddr); end
`else
         if (m_trap || mis) m_st = m_st;
`endif
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_stall();
      test_redirect_over_stall();
      test_wrap();
      test_async_reset();
`ifdef FETCH_MISALIGN_TRAP_EN
      test_misalign();
`else
      test_align_forced();
`endif
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within 200000 time units");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
